// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI mode-0 slave owning the PWM configuration register file.
// Frames are 16 bits MSB first: {rw, addr[6:0], data[7:0]}, with readback.
module spi_pwm_cfg_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4,
   parameter int FRAME_BITS  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic       cipo,
   output logic       cipo_oe,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   localparam int         NREGS   = 5;
   localparam logic [4:0] FB      = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_MAX = 5'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic sclk_dly_q, sclk_dly_d;
   logic ncs_dly_q, ncs_dly_d;

   logic armed_q, armed_d;
   logic pend_q, pend_d;
   logic [4:0] bit_cnt_q, bit_cnt_d;
   logic [15:0] shift_in_q, shift_in_d;
   logic [7:0] shift_out_q, shift_out_d;
   logic [7:0] regs_q [NREGS];
   logic [7:0] regs_d [NREGS];
   logic wr_strobe_q, wr_strobe_d;
   logic frame_err_q, frame_err_d;
   logic cipo_oe_q, cipo_oe_d;

   logic sclk_s, ncs_s, copi_s;
   logic sclk_rise, sclk_fall;
   logic ncs_rise, ncs_fall;
   logic start, take;
   logic [4:0] cnt_eff;
   logic [6:0] rd_addr;
   logic [7:0] rd_data;
   logic cm_rw;
   logic [6:0] cm_addr;
   logic [7:0] cm_data;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign ncs_rise  = ncs_s & ~ncs_dly_q;
   assign ncs_fall  = ~ncs_s & ncs_dly_q;

   // A pending fall seen during COMMIT starts the next frame.
   assign start = armed_q & (ncs_fall | pend_q);

   // On a coincident last edge the sample lands only if room remains.
   assign take    = sclk_rise & (~ncs_rise | (bit_cnt_q < FB));
   assign cnt_eff = bit_cnt_q
                  + {4'd0, sclk_rise & (bit_cnt_q < FB)};

   assign rd_addr = {shift_in_q[5:0], copi_s};
   assign cm_rw   = shift_in_q[15];
   assign cm_addr = shift_in_q[14:8];
   assign cm_data = shift_in_q[7:0];

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (int'(rd_addr) == i && i <= MAX_ADDR) begin
            rd_data = regs_q[i];
         end
      end
   end

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_dly_d  = sclk_s;
      ncs_dly_d   = ncs_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ncs_rise) begin
               state_d = (cnt_eff == FB) ? COMMIT : IDLE;
            end
         end
         COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      armed_d     = armed_q | ncs_s;
      pend_d      = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      frame_err_d = 1'b0;
      cipo_oe_d   = (state_d == SHIFT) & ~ncs_s;
      unique case (state_q)
         IDLE: begin
            shift_out_d = '0;
            if (start) begin
               bit_cnt_d  = '0;
               shift_in_d = '0;
            end
         end
         SHIFT: begin
            if (take) begin
               shift_in_d = {shift_in_q[14:0], copi_s};
               if (bit_cnt_q != CNT_MAX) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
               if (bit_cnt_q == 5'd7 && !shift_in_q[6]) begin
                  shift_out_d = rd_data;
               end
            end else if (sclk_fall && bit_cnt_q >= 5'd9) begin
               shift_out_d = {shift_out_q[6:0], 1'b0};
            end
            if (ncs_rise) begin
               shift_out_d = '0;
               frame_err_d = (cnt_eff != FB);
            end
         end
         COMMIT: begin
            pend_d      = ncs_fall;
            shift_out_d = '0;
            for (int i = 0; i < NREGS; i++) begin
               if (cm_rw && int'(cm_addr) == i && i <= MAX_ADDR) begin
                  regs_d[i]   = cm_data;
                  wr_strobe_d = 1'b1;
               end
            end
         end
         default: shift_out_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         ncs_sync_q  <= '0;
         copi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         ncs_dly_q   <= 1'b0;
         armed_q     <= 1'b0;
         pend_q      <= 1'b0;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         regs_q      <= '{default: '0};
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         cipo_oe_q   <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         copi_sync_q <= copi_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         ncs_dly_q   <= ncs_dly_d;
         armed_q     <= armed_d;
         pend_q      <= pend_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
         cipo_oe_q   <= cipo_oe_d;
      end
   end

   assign cipo            = shift_out_q[7];
   assign cipo_oe         = cipo_oe_q;
   assign wr_strobe       = wr_strobe_q;
   assign frame_err       = frame_err_q;
   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Directed bench for spi_pwm_cfg_ctrl: SPI at clk/10, hand-computed
// expectations for writes, readback, bad frames, reset and back-to-back.
module tb_spi_pwm_cfg_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic ncs = 1'b1;
   logic copi = 1'b0;
   logic cipo, cipo_oe, wr_strobe, frame_err;
   logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

   int nvec = 0;
   int nerr = 0;
   int wr_cnt = 0;
   int ferr_cnt = 0;

   always #5 clk = ~clk;

   spi_pwm_cfg_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .ncs             (ncs),
      .copi            (copi),
      .cipo            (cipo),
      .cipo_oe         (cipo_oe),
      .en_reg_out_7_0  (out_lo),
      .en_reg_out_15_8 (out_hi),
      .en_reg_pwm_7_0  (pwm_lo),
      .en_reg_pwm_15_8 (pwm_hi),
      .pwm_duty_cycle  (duty),
      .wr_strobe       (wr_strobe),
      .frame_err       (frame_err)
   );

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) wr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clocks nbits with ncs low; leaves ncs low and sclk low.
   task automatic spi_bits(input logic [15:0] tx, input int nbits,
                           output logic [7:0] rx);
      rx = '0;
      ncs = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         copi = (i < 16) ? tx[15-i] : 1'b0;
         tick(5);
         if (i >= 8 && i < 16) rx[15-i] = cipo;
         sclk = 1'b1;
         tick(5);
         sclk = 1'b0;
      end
      tick(5);
   endtask

   task automatic end_frame(input int gap);
      ncs = 1'b1;
      tick(gap);
   endtask

   task automatic test_reset();
      logic [43:0] v;
      rst_n = 1'b0;
      tick(3);
      v = {out_lo, out_hi, pwm_lo, pwm_hi, duty,
           cipo, cipo_oe, wr_strobe, frame_err};
      nvec++;
      if (v !== 44'd0) begin
         nerr++;
         $display("FAIL reset_outputs: got %h, expected 0", v);
      end
      rst_n = 1'b1;
      tick(6);
      v = {out_lo, out_hi, pwm_lo, pwm_hi, duty,
           cipo, cipo_oe, wr_strobe, frame_err};
      nvec++;
      if (v !== 44'd0) begin
         nerr++;
         $display("FAIL post_reset_outputs: got %h, expected 0", v);
      end
   endtask

   task automatic test_write();
      logic [7:0] rx;
      int w0;
      w0 = wr_cnt;
      spi_bits(16'h80F0, 16, rx);
      nvec++;
      if (cipo_oe !== 1'b1) begin
         nerr++;
         $display("FAIL oe_in_frame: got %b, expected 1", cipo_oe);
      end
      ncs = 1'b1;
      tick(3);
      nvec++;
      if (out_lo !== 8'h00 || wr_strobe !== 1'b0) begin
         nerr++;
         $display("FAIL wr_early: got reg %h strobe %b, expected 00 0",
                  out_lo, wr_strobe);
      end
      tick(1);
      nvec++;
      if (out_lo !== 8'hF0 || wr_strobe !== 1'b1) begin
         nerr++;
         $display("FAIL wr_commit: got reg %h strobe %b, expected f0 1",
                  out_lo, wr_strobe);
      end
      tick(1);
      nvec++;
      if (wr_strobe !== 1'b0) begin
         nerr++;
         $display("FAIL wr_strobe_width: got %b, expected 0", wr_strobe);
      end
      tick(6);
      nvec++;
      if (wr_cnt - w0 !== 1) begin
         nerr++;
         $display("FAIL wr_strobe_count: got %0d, expected 1", wr_cnt - w0);
      end
      nvec++;
      if ({out_hi, pwm_lo, pwm_hi, duty} !== 32'd0) begin
         nerr++;
         $display("FAIL wr_others: got %h, expected 0",
                  {out_hi, pwm_lo, pwm_hi, duty});
      end
      nvec++;
      if (cipo_oe !== 1'b0) begin
         nerr++;
         $display("FAIL oe_idle: got %b, expected 0", cipo_oe);
      end
   endtask

   task automatic test_readback();
      logic [7:0] rx;
      spi_bits(16'h8480, 16, rx);
      end_frame(10);
      nvec++;
      if (duty !== 8'h80) begin
         nerr++;
         $display("FAIL duty_write: got %h, expected 80", duty);
      end
      spi_bits(16'h0400, 16, rx);
      end_frame(10);
      nvec++;
      if (rx !== 8'h80) begin
         nerr++;
         $display("FAIL read_duty: got %h, expected 80", rx);
      end
      spi_bits(16'h0000, 16, rx);
      end_frame(10);
      nvec++;
      if (rx !== 8'hF0) begin
         nerr++;
         $display("FAIL read_reg0: got %h, expected f0", rx);
      end
   endtask

   task automatic test_bad_addr();
      logic [7:0] rx;
      int w0;
      w0 = wr_cnt;
      spi_bits(16'h85AA, 16, rx);
      end_frame(10);
      nvec++;
      if (wr_cnt - w0 !== 0) begin
         nerr++;
         $display("FAIL bad_addr_strobe: got %0d, expected 0", wr_cnt - w0);
      end
      nvec++;
      if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'hF000000080) begin
         nerr++;
         $display("FAIL bad_addr_regs: got %h, expected f000000080",
                  {out_lo, out_hi, pwm_lo, pwm_hi, duty});
      end
      spi_bits(16'h0500, 16, rx);
      end_frame(10);
      nvec++;
      if (rx !== 8'h00) begin
         nerr++;
         $display("FAIL bad_addr_read: got %h, expected 00", rx);
      end
   endtask

   task automatic test_frame_err();
      logic [7:0] rx;
      int f0, w0;
      f0 = ferr_cnt;
      w0 = wr_cnt;
      spi_bits(16'h81FF, 12, rx);
      end_frame(10);
      nvec++;
      if (ferr_cnt - f0 !== 1) begin
         nerr++;
         $display("FAIL ferr_short: got %0d, expected 1", ferr_cnt - f0);
      end
      spi_bits(16'h81FF, 17, rx);
      end_frame(10);
      nvec++;
      if (ferr_cnt - f0 !== 2) begin
         nerr++;
         $display("FAIL ferr_long: got %0d, expected 2", ferr_cnt - f0);
      end
      nvec++;
      if (wr_cnt - w0 !== 0 ||
          {out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'hF000000080) begin
         nerr++;
         $display("FAIL ferr_regs: got %h strobes %0d, expected f000000080 0",
                  {out_lo, out_hi, pwm_lo, pwm_hi, duty}, wr_cnt - w0);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] rx;
      int w0, f0;
      spi_bits(16'h8233, 8, rx);
      rst_n = 1'b0;
      tick(2);
      nvec++;
      if ({out_lo, duty} !== 16'h0000) begin
         nerr++;
         $display("FAIL mid_reset_clear: got %h, expected 0000",
                  {out_lo, duty});
      end
      rst_n = 1'b1;
      tick(2);
      w0 = wr_cnt;
      f0 = ferr_cnt;
      spi_bits(16'h3300, 8, rx);
      end_frame(10);
      nvec++;
      if (pwm_lo !== 8'h00 || wr_cnt - w0 !== 0 || ferr_cnt - f0 !== 0) begin
         nerr++;
         $display("FAIL mid_reset_discard: got %h/%0d/%0d, expected 00/0/0",
                  pwm_lo, wr_cnt - w0, ferr_cnt - f0);
      end
      spi_bits(16'h8233, 16, rx);
      end_frame(10);
      nvec++;
      if (pwm_lo !== 8'h33 || wr_cnt - w0 !== 1) begin
         nerr++;
         $display("FAIL mid_reset_next: got %h/%0d, expected 33/1",
                  pwm_lo, wr_cnt - w0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rx;
      int w0;
      w0 = wr_cnt;
      spi_bits(16'h8155, 16, rx);
      ncs = 1'b1;
      tick(4);
      spi_bits(16'h830F, 16, rx);
      ncs = 1'b1;
      tick(1);
      spi_bits(16'h80A5, 16, rx);
      end_frame(10);
      nvec++;
      if (wr_cnt - w0 !== 3) begin
         nerr++;
         $display("FAIL b2b_strobes: got %0d, expected 3", wr_cnt - w0);
      end
      nvec++;
      if ({out_lo, out_hi, pwm_hi} !== 24'hA5550F) begin
         nerr++;
         $display("FAIL b2b_regs: got %h, expected a5550f",
                  {out_lo, out_hi, pwm_hi});
      end
      spi_bits(16'h0100, 16, rx);
      end_frame(10);
      nvec++;
      if (rx !== 8'h55) begin
         nerr++;
         $display("FAIL b2b_read1: got %h, expected 55", rx);
      end
      spi_bits(16'h0300, 16, rx);
      end_frame(10);
      nvec++;
      if (rx !== 8'h0F) begin
         nerr++;
         $display("FAIL b2b_read3: got %h, expected 0f", rx);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_bad_addr();
      test_frame_err();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
